// File: rtl/ysyx_23060180_mem_ctrl.sv
// Memory/device controller behind the ysyx_23060180 core's memory port:
// word-organised RAM, serial TX register and a 64-bit RTC, all answered with 1-cycle latency.
module ysyx_23060180_mem_ctrl #(
    parameter logic [31:0] MEM_BASE    = 32'h8000_0000,
    parameter int          MEM_WORDS   = 16384,
    parameter logic [31:0] SERIAL_ADDR = 32'ha000_03f8,
    parameter logic [31:0] RTC_ADDR    = 32'ha000_0048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_raddr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wbit_en,
    output logic [31:0] mem_rdata,
    output logic        serial_valid,
    output logic [7:0]  serial_data,
    output logic        access_fault
);
    localparam int          IDX_W       = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES   = 32'(MEM_WORDS) << 2;
    localparam logic [29:0] SERIAL_WORD = SERIAL_ADDR[31:2];
    localparam logic [29:0] RTC_LO_WORD = RTC_ADDR[31:2];
    localparam logic [29:0] RTC_HI_WORD = RTC_LO_WORD + 30'd1;

    logic [31:0]      ram [MEM_WORDS];
    logic [63:0]      rtc_count;
    logic [31:0]      rtc_snap;

    logic [31:0]      ram_off;
    logic [IDX_W-1:0] ram_idx;
    logic [1:0]       off;
    logic             hit_ram;
    logic             hit_serial;
    logic             hit_rtc_lo;
    logic             hit_rtc_hi;
    logic             mapped;

    logic [31:0]      rd_word;
    logic [31:0]      rd_shifted;
    logic             rd_fault;

    logic [3:0]       size_mask;
    logic             size_ok;
    logic             misaligned;
    logic [3:0]       strobe;
    logic [31:0]      wr_data_sh;
    logic             wr_fault;
    logic             wr_ok;
    logic             ram_we;
    logic             serial_we;

    // Offset-based range check stays correct even if MEM_BASE sits near the top of the map
    assign ram_off    = mem_raddr - MEM_BASE;
    assign ram_idx    = ram_off[IDX_W+1:2];
    assign off        = mem_raddr[1:0];
    assign hit_ram    = (mem_raddr >= MEM_BASE) && (ram_off < MEM_BYTES);
    assign hit_serial = (mem_raddr[31:2] == SERIAL_WORD);
    assign hit_rtc_lo = (mem_raddr[31:2] == RTC_LO_WORD);
    assign hit_rtc_hi = (mem_raddr[31:2] == RTC_HI_WORD);
    assign mapped     = hit_ram || hit_serial || hit_rtc_lo || hit_rtc_hi;

    always_comb begin
        rd_word = 32'd0;
        if (hit_ram)
            rd_word = ram[ram_idx];
        else if (hit_rtc_lo)
            rd_word = rtc_count[31:0];
        else if (hit_rtc_hi)
            rd_word = rtc_snap;
    end

    assign rd_shifted = rd_word >> {off, 3'b000};
    assign rd_fault   = mem_rd && !mapped;

    always_comb begin
        size_mask = 4'b0000;
        size_ok   = 1'b1;
        case (mem_wbit_en)
            4'd1:    size_mask = 4'b0001;
            4'd2:    size_mask = 4'b0011;
            4'd4:    size_mask = 4'b1111;
            default: size_ok   = 1'b0;
        endcase
    end

    assign misaligned = ((mem_wbit_en == 4'd2) && (off == 2'd3)) ||
                        ((mem_wbit_en == 4'd4) && (off != 2'd0));
    assign strobe     = size_mask << off;
    assign wr_data_sh = mem_wdata << {off, 3'b000};
    assign wr_fault   = mem_wr && (!mapped || !size_ok || misaligned ||
                                   (hit_serial && (mem_wbit_en != 4'd1)));
    assign wr_ok      = mem_wr && !wr_fault;
    assign ram_we     = wr_ok && hit_ram;
    assign serial_we  = wr_ok && hit_serial && !hit_ram;

    // RAM has no reset; the rst gate keeps a write coinciding with reset from landing
    always_ff @(posedge clk) begin
        if (!rst && ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (strobe[i])
                    ram[ram_idx][8*i +: 8] <= wr_data_sh[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rtc_count    <= 64'd0;
            rtc_snap     <= 32'd0;
            mem_rdata    <= 32'd0;
            serial_valid <= 1'b0;
            serial_data  <= 8'd0;
            access_fault <= 1'b0;
        end else begin
            rtc_count    <= rtc_count + 64'd1;
            serial_valid <= serial_we;
            access_fault <= rd_fault || wr_fault;
            if (serial_we)
                serial_data <= mem_wdata[7:0];
            if (mem_rd) begin
                mem_rdata <= rd_shifted;
                // Latching the high half alongside the low read gives a tear-free 64-bit read
                if (hit_rtc_lo && !hit_ram)
                    rtc_snap <= rtc_count[63:32];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060180_mem_ctrl.sv
// Self-checking bench for ysyx_23060180_mem_ctrl: directed vector table, RTC/reset
// sequences, then random traffic against a byte-addressed reference model.
module tb_ysyx_23060180_mem_ctrl;
    localparam logic [31:0] MEM_BASE    = 32'h8000_0000;
    localparam logic [31:0] SERIAL_ADDR = 32'ha000_03f8;
    localparam logic [31:0] RTC_ADDR    = 32'ha000_0048;
    localparam logic [31:0] WIN         = 32'h8000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] mem_raddr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [3:0]  mem_wbit_en = 4'd0;
    logic [31:0] mem_rdata;
    logic        serial_valid;
    logic [7:0]  serial_data;
    logic        access_fault;

    int vec_count = 0;
    int miscompares = 0;

    logic [7:0] win_bytes [64];

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  size;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        logic        exp_sv;
        logic [7:0]  exp_sd;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ysyx_23060180_mem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_raddr    (mem_raddr),
        .mem_wdata    (mem_wdata),
        .mem_wbit_en  (mem_wbit_en),
        .mem_rdata    (mem_rdata),
        .serial_valid (serial_valid),
        .serial_data  (serial_data),
        .access_fault (access_fault)
    );

    function automatic vec_t mk(input string name, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] size, input logic chk,
                                input logic [31:0] exp_rdata, input logic exp_fault,
                                input logic exp_sv, input logic [7:0] exp_sd);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.size = size; v.chk_rdata = chk; v.exp_rdata = exp_rdata;
        v.exp_fault = exp_fault; v.exp_sv = exp_sv; v.exp_sd = exp_sd;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Called at a negedge; returns at the following negedge with the results visible
    task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] size);
        mem_rd      = rd;
        mem_wr      = wr;
        mem_raddr   = addr;
        mem_wdata   = wdata;
        mem_wbit_en = size;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_vector(input vec_t v);
        check_output({v.name, ".fault"}, {31'd0, access_fault}, {31'd0, v.exp_fault});
        check_output({v.name, ".serial_valid"}, {31'd0, serial_valid}, {31'd0, v.exp_sv});
        if (v.exp_sv)
            check_output({v.name, ".serial_data"}, {24'd0, serial_data}, {24'd0, v.exp_sd});
        if (v.chk_rdata)
            check_output({v.name, ".rdata"}, mem_rdata, v.exp_rdata);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_output({tag, ".rdata"}, mem_rdata, 32'd0);
        check_output({tag, ".fault"}, {31'd0, access_fault}, 32'd0);
        check_output({tag, ".serial_valid"}, {31'd0, serial_valid}, 32'd0);
        check_output({tag, ".serial_data"}, {24'd0, serial_data}, 32'd0);
    endtask

    // Reference read: bytes from addr up to the end of its word, zero above
    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] r = 32'd0;
        int base = int'(addr - WIN) & ~3;
        int o = int'(addr[1:0]);
        for (int i = 0; i < 4 - o; i++)
            r[8*i +: 8] = win_bytes[base + o + i];
        return r;
    endfunction

    initial begin
        logic [31:0] hold_rdata;

        vecs.push_back(mk("preload",      0, 1, MEM_BASE,       32'h0010_0073, 4, 0, 32'h0,          0, 0, 8'h00));
        vecs.push_back(mk("rd_base",      1, 0, MEM_BASE,       32'h0,         0, 1, 32'h0010_0073, 0, 0, 8'h00));
        vecs.push_back(mk("hold",         0, 0, MEM_BASE,       32'h0,         0, 1, 32'h0010_0073, 0, 0, 8'h00));
        vecs.push_back(mk("wr_word",      0, 1, 32'h8000_0010,  32'hdead_beef, 4, 1, 32'h0010_0073, 0, 0, 8'h00));
        vecs.push_back(mk("wr_byte",      0, 1, 32'h8000_0011,  32'h0000_00aa, 1, 0, 32'h0,          0, 0, 8'h00));
        vecs.push_back(mk("rd_word",      1, 0, 32'h8000_0010,  32'h0,         0, 1, 32'hdead_aaef, 0, 0, 8'h00));
        vecs.push_back(mk("rd_off2",      1, 0, 32'h8000_0012,  32'h0,         0, 1, 32'h0000_dead, 0, 0, 8'h00));
        vecs.push_back(mk("wr_mis_half",  0, 1, 32'h8000_0013,  32'h0000_1234, 2, 1, 32'h0000_dead, 1, 0, 8'h00));
        vecs.push_back(mk("rd_after_mis", 1, 0, 32'h8000_0010,  32'h0,         0, 1, 32'hdead_aaef, 0, 0, 8'h00));
        vecs.push_back(mk("rd_unmapped",  1, 0, 32'h9000_0000,  32'h0,         0, 1, 32'h0,          1, 0, 8'h00));
        vecs.push_back(mk("serial_byte",  0, 1, SERIAL_ADDR,    32'h0000_0041, 1, 1, 32'h0,          0, 1, 8'h41));
        vecs.push_back(mk("serial_idle",  0, 0, SERIAL_ADDR,    32'h0,         0, 0, 32'h0,          0, 0, 8'h00));
        vecs.push_back(mk("serial_word",  0, 1, SERIAL_ADDR,    32'h1234_5678, 4, 0, 32'h0,          1, 0, 8'h00));
        vecs.push_back(mk("rd_word2",     1, 0, 32'h8000_0010,  32'h0,         0, 1, 32'hdead_aaef, 0, 0, 8'h00));
        vecs.push_back(mk("rd_serial",    1, 0, SERIAL_ADDR,    32'h0,         0, 1, 32'h0,          0, 0, 8'h00));
        vecs.push_back(mk("wr_init20",    0, 1, 32'h8000_0020,  32'h1111_1111, 4, 0, 32'h0,          0, 0, 8'h00));
        vecs.push_back(mk("rdwr_same",    1, 1, 32'h8000_0020,  32'h2222_2222, 4, 1, 32'h1111_1111, 0, 0, 8'h00));
        vecs.push_back(mk("rd_new",       1, 0, 32'h8000_0020,  32'h0,         0, 1, 32'h2222_2222, 0, 0, 8'h00));
        vecs.push_back(mk("wr_badsize",   0, 1, 32'h8000_0020,  32'h3333_3333, 3, 0, 32'h0,          1, 0, 8'h00));
        vecs.push_back(mk("wr_mis_word",  0, 1, 32'h8000_0022,  32'h4444_4444, 4, 0, 32'h0,          1, 0, 8'h00));
        vecs.push_back(mk("wr_half_hi",   0, 1, 32'h8000_0022,  32'h0000_beef, 2, 0, 32'h0,          0, 0, 8'h00));
        vecs.push_back(mk("rd_half",      1, 0, 32'h8000_0020,  32'h0,         0, 1, 32'hbeef_2222, 0, 0, 8'h00));
        vecs.push_back(mk("rd_off3",      1, 0, 32'h8000_0023,  32'h0,         0, 1, 32'h0000_00be, 0, 0, 8'h00));
        vecs.push_back(mk("wr_rtc",       0, 1, RTC_ADDR,       32'hffff_ffff, 4, 0, 32'h0,          0, 0, 8'h00));
        vecs.push_back(mk("wr_last",      0, 1, 32'h8000_fffc,  32'hcafe_f00d, 4, 0, 32'h0,          0, 0, 8'h00));
        vecs.push_back(mk("rd_last",      1, 0, 32'h8000_ffff,  32'h0,         0, 1, 32'h0000_00ca, 0, 0, 8'h00));
        vecs.push_back(mk("rd_past_end",  1, 0, 32'h8001_0000,  32'h0,         0, 1, 32'h0,          1, 0, 8'h00));
        vecs.push_back(mk("rd_below",     1, 0, 32'h7fff_fffc,  32'h0,         0, 1, 32'h0,          1, 0, 8'h00));
        vecs.push_back(mk("idle",         0, 0, 32'h0,          32'h0,         0, 1, 32'h0,          0, 0, 8'h00));
        vecs.push_back(mk("wr_unmapped",  0, 1, 32'h9000_0000,  32'h0000_0001, 1, 1, 32'h0,          1, 0, 8'h00));

        // Reset phase: every output must read zero
        @(negedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size);
            check_vector(vecs[i]);
        end

        // RTC snapshot: force the low half to all-ones so the high half ticks over
        force dut.rtc_count = 64'h0000_0000_ffff_ffff;
        mem_rd = 1'b1; mem_wr = 1'b0; mem_raddr = RTC_ADDR;
        @(posedge clk);
        #1 release dut.rtc_count;
        @(negedge clk);
        check_output("rtc_lo_forced", mem_rdata, 32'hffff_ffff);
        apply_stimulus(0, 0, 32'h0, 32'h0, 0);
        apply_stimulus(0, 0, 32'h0, 32'h0, 0);
        apply_stimulus(1, 0, RTC_ADDR + 32'd4, 32'h0, 0);
        check_output("rtc_hi_snapshot", mem_rdata, 32'h0);
        apply_stimulus(1, 0, RTC_ADDR, 32'h0, 0);
        apply_stimulus(1, 0, RTC_ADDR + 32'd4, 32'h0, 0);
        check_output("rtc_hi_after_wrap", mem_rdata, 32'h1);

        // Reset arriving mid-write must cancel the write and any fault
        apply_stimulus(0, 1, 32'h8000_0030, 32'h5555_5555, 4);
        check_output("wr30.fault", {31'd0, access_fault}, 32'd0);
        mem_rd = 1'b0; mem_wr = 1'b1; mem_raddr = 32'h8000_0030;
        mem_wdata = 32'h6666_6666; mem_wbit_en = 4'd4;
        rst = 1'b1;
        #1 check_zero_outputs("rst_async");
        @(posedge clk);
        @(negedge clk);
        check_zero_outputs("rst_mid_write");
        apply_stimulus(0, 1, 32'h9000_0000, 32'h0, 3);
        check_zero_outputs("rst_bad_write");
        rst = 1'b0;
        apply_stimulus(1, 0, RTC_ADDR, 32'h0, 0);
        check_output("rtc_after_reset_0", mem_rdata, 32'd0);
        apply_stimulus(1, 0, RTC_ADDR, 32'h0, 0);
        check_output("rtc_after_reset_1", mem_rdata, 32'd1);
        apply_stimulus(1, 0, RTC_ADDR + 32'd4, 32'h0, 0);
        check_output("rtc_hi_after_reset", mem_rdata, 32'd0);
        apply_stimulus(1, 0, 32'h8000_0030, 32'h0, 0);
        check_output("rd30_after_reset", mem_rdata, 32'h5555_5555);

        // Random traffic over a 64-byte RAM window plus devices and holes
        for (int w = 0; w < 16; w++) begin
            logic [31:0] d;
            d = $urandom;
            apply_stimulus(0, 1, WIN + 32'(4 * w), d, 4);
            for (int b = 0; b < 4; b++)
                win_bytes[4 * w + b] = d[8*b +: 8];
            check_output("rand_init.fault", {31'd0, access_fault}, 32'd0);
        end
        apply_stimulus(1, 0, WIN, 32'h0, 0);
        hold_rdata = model_read(WIN);
        check_output("rand_init.rdata", mem_rdata, hold_rdata);

        for (int n = 0; n < 400; n++) begin
            int          cat;
            int          k;
            int          o;
            logic        rd;
            logic        wr;
            logic [31:0] addr;
            logic [31:0] wdata;
            logic [3:0]  size;
            logic        is_win;
            logic        is_ser;
            logic        mapped;
            logic        legal;
            logic        exp_fault;
            logic        exp_sv;

            cat    = $urandom_range(0, 9);
            rd     = 1'($urandom_range(0, 1));
            wr     = 1'($urandom_range(0, 1));
            wdata  = $urandom;
            is_win = 1'b0;
            is_ser = 1'b0;
            mapped = 1'b1;
            if (cat < 7) begin
                addr   = WIN + 32'($urandom_range(0, 63));
                is_win = 1'b1;
            end else if (cat == 7) begin
                addr   = SERIAL_ADDR + 32'($urandom_range(0, 3));
                is_ser = 1'b1;
            end else if (cat == 8) begin
                addr   = {4'h9, 28'($urandom)};
                mapped = 1'b0;
            end else begin
                addr = RTC_ADDR + 32'($urandom_range(0, 7));
                rd   = 1'b0;
            end
            if ($urandom_range(0, 4) != 0) begin
                k    = $urandom_range(0, 2);
                size = (k == 0) ? 4'd1 : (k == 1) ? 4'd2 : 4'd4;
            end else begin
                size = 4'($urandom_range(0, 15));
            end
            o     = int'(addr[1:0]);
            legal = (size == 4'd1 || size == 4'd2 || size == 4'd4) && (o + int'(size) <= 4);

            exp_fault = (rd && !mapped) ||
                        (wr && (!mapped || !legal || (is_ser && size != 4'd1)));
            exp_sv    = wr && is_ser && (size == 4'd1);
            if (rd)
                hold_rdata = is_win ? model_read(addr) : 32'd0;

            apply_stimulus(rd, wr, addr, wdata, size);
            check_output("rand.fault", {31'd0, access_fault}, {31'd0, exp_fault});
            check_output("rand.serial_valid", {31'd0, serial_valid}, {31'd0, exp_sv});
            if (exp_sv)
                check_output("rand.serial_data", {24'd0, serial_data}, {24'd0, wdata[7:0]});
            check_output("rand.rdata", mem_rdata, hold_rdata);

            if (wr && is_win && legal) begin
                for (int b = 0; b < int'(size); b++)
                    win_bytes[int'(addr - WIN) + b] = wdata[8*b +: 8];
            end
        end

        apply_stimulus(0, 0, 32'h0, 32'h0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
